// File: rtl/viterbi_pkg.sv
// Shared types for the radix-4 Viterbi decoder: trellis widths, decision
// vector type, traceback FSM encoding and the predecessor-select helper.
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam int STATE_W    = 2;
   localparam int DEC_W      = 2 * NUM_STATES;

   typedef logic [STATE_W-1:0] state_t;
   typedef logic [DEC_W-1:0]   dec_vec_t;

   typedef enum logic [1:0] {
      TB_WRITE  = 2'd0,
      TB_TRACE  = 2'd1,
      TB_OUTPUT = 2'd2
   } tb_fsm_t;

   // Predecessor of state s: the two-bit field [2s+1:2s] of the decision vector.
   function automatic state_t pred_state(input dec_vec_t dec, input state_t s);
      dec_vec_t shifted;
      shifted = dec >> {s, 1'b0};
      return shifted[STATE_W-1:0];
   endfunction

endpackage

// File: rtl/traceback_unit_lifo.sv
// Small LIFO used to reverse the traced state sequence into chronological
// order. Synchronous clear, asynchronous reset; the top entry is presented
// combinationally so the consumer can register it on the pop cycle.
module lifo_buf #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_top,
   output logic [CNT_W-1:0] o_count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] stack_mem [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             can_push;
   logic             can_pop;

   assign can_push = (count_q < CNT_W'(DEPTH));
   assign can_pop  = (count_q != {CNT_W{1'b0}});
   assign wr_idx   = IDX_W'(count_q);
   assign rd_idx   = IDX_W'(count_q - CNT_W'(1));
   assign o_top    = stack_mem[rd_idx];
   assign o_count  = count_q;

   // Occupancy update: clear wins, simultaneous push/pop leaves the depth unchanged.
   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = {CNT_W{1'b0}};
      end else if (i_push && !i_pop && can_push) begin
         count_d = count_q + CNT_W'(1);
      end else if (i_pop && !i_push && can_pop) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless outside [0, count).
   always_ff @(posedge clk) begin
      if (i_push && !i_pop && !i_clr && can_push) begin
         stack_mem[wr_idx] <= i_din;
      end
   end

endmodule

// File: rtl/traceback_unit.sv
// Survivor memory and traceback for the radix-4 Viterbi decoder. Stores one
// decision vector per trellis step, traces back from the best state once a
// frame is complete, and emits the decoded bit pairs oldest-first.
module traceback_unit #(
   parameter int NUM_STATES  = 4,
   parameter int FRAME_STEPS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_en_td,
   input  logic                    i_en_t,
   input  logic [2*NUM_STATES-1:0] i_dec,
   input  logic [1:0]              i_best_state,
   output logic [1:0]              o_bits,
   output logic                    o_valid,
   output logic                    o_frame_done,
   output logic                    o_busy,
   output logic                    o_overrun
);

   import viterbi_pkg::*;

   localparam int               PTR_W    = (FRAME_STEPS > 1) ? $clog2(FRAME_STEPS) : 1;
   localparam int               CNT_W    = $clog2(FRAME_STEPS + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_STEPS - 1);
   localparam logic [CNT_W-1:0] ONE_LEFT = CNT_W'(1);

   tb_fsm_t          state_q, state_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   state_t           cur_state_q, cur_state_d;
   logic [1:0]       bits_q, bits_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;

   dec_vec_t         survivor_mem [FRAME_STEPS];
   logic             mem_we;
   state_t           trace_pred;

   logic             lifo_push;
   logic             lifo_pop;
   logic             lifo_clr;
   state_t           lifo_top;
   logic [CNT_W-1:0] lifo_count;

   // Predecessor of the current traced state at the step being read.
   assign trace_pred = pred_state(survivor_mem[rptr_q], cur_state_q);

   // The stack is only ever filled in TRACE and drained in OUTPUT; hold it empty while writing.
   assign lifo_clr = (state_q == TB_WRITE);

   lifo_buf #(
      .DEPTH (FRAME_STEPS),
      .WIDTH (STATE_W),
      .CNT_W (CNT_W)
   ) u_lifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (lifo_clr),
      .i_push  (lifo_push),
      .i_pop   (lifo_pop),
      .i_din   (cur_state_q),
      .o_top   (lifo_top),
      .o_count (lifo_count)
   );

   // Next-state, pointer and output computation for the write/trace/output sequence.
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      cur_state_d = cur_state_q;
      bits_d      = 2'b00;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      overrun_d   = 1'b0;
      mem_we      = 1'b0;
      lifo_push   = 1'b0;
      lifo_pop    = 1'b0;
      case (state_q)
         TB_WRITE: begin
            if (i_en_td) begin
               mem_we = 1'b1;
               if (wptr_q == LAST_PTR) begin
                  cur_state_d = i_best_state;
                  rptr_d      = LAST_PTR;
                  state_d     = TB_TRACE;
               end else begin
                  wptr_d = wptr_q + PTR_W'(1);
               end
            end else begin
               state_d = TB_WRITE;
            end
         end
         TB_TRACE: begin
            overrun_d = i_en_td;
            if (i_en_t) begin
               lifo_push   = 1'b1;
               cur_state_d = trace_pred;
               if (rptr_q == {PTR_W{1'b0}}) begin
                  state_d = TB_OUTPUT;
               end else begin
                  rptr_d = rptr_q - PTR_W'(1);
               end
            end else begin
               state_d = TB_TRACE;
            end
         end
         TB_OUTPUT: begin
            overrun_d = i_en_td;
            if (i_en_t) begin
               lifo_pop = 1'b1;
               bits_d   = lifo_top;
               valid_d  = 1'b1;
               if (lifo_count == ONE_LEFT) begin
                  done_d  = 1'b1;
                  wptr_d  = {PTR_W{1'b0}};
                  state_d = TB_WRITE;
               end else begin
                  state_d = TB_OUTPUT;
               end
            end else begin
               state_d = TB_OUTPUT;
            end
         end
         default: begin
            state_d = TB_WRITE;
         end
      endcase
      busy_d = (state_d != TB_WRITE);
   end

   // FSM, pointers, traced state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= TB_WRITE;
         wptr_q      <= {PTR_W{1'b0}};
         rptr_q      <= {PTR_W{1'b0}};
         cur_state_q <= 2'b00;
         bits_q      <= 2'b00;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cur_state_q <= cur_state_d;
         bits_q      <= bits_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   // Survivor memory: one decision vector per trellis step, no reset needed.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         survivor_mem[wptr_q] <= dec_vec_t'(i_dec);
      end
   end

   assign o_bits       = bits_q;
   assign o_valid      = valid_q;
   assign o_frame_done = done_q;
   assign o_busy       = busy_q;
   assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Directed and randomised bench for traceback_unit with a 4-step frame.
module tb_traceback_unit;

   localparam int FS = 4;

   logic       clk;
   logic       rst;
   logic       i_en_td;
   logic       i_en_t;
   logic [7:0] i_dec;
   logic [1:0] i_best_state;
   logic [1:0] o_bits;
   logic       o_valid;
   logic       o_frame_done;
   logic       o_busy;
   logic       o_overrun;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] bits;
      logic       done;
      int         cyc;
   } out_t;

   typedef struct packed {
      logic [31:0] decs;
      logic [1:0]  best;
      logic [7:0]  exp;
   } vec_t;

   out_t out_q [$];
   int   rd_idx     = 0;
   int   ncyc       = 0;
   int   ovr_cnt    = 0;
   int   stray_done = 0;
   int   last_wr_n  = 0;
   vec_t vecs [6];

   traceback_unit #(
      .NUM_STATES  (4),
      .FRAME_STEPS (FS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_en_td      (i_en_td),
      .i_en_t       (i_en_t),
      .i_dec        (i_dec),
      .i_best_state (i_best_state),
      .o_bits       (o_bits),
      .o_valid      (o_valid),
      .o_frame_done (o_frame_done),
      .o_busy       (o_busy),
      .o_overrun    (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (o_valid) out_q.push_back('{o_bits, o_frame_done, ncyc});
      if (o_frame_done && !o_valid) stray_done <= stray_done + 1;
      if (o_overrun) ovr_cnt <= ovr_cnt + 1;
      ncyc <= ncyc + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [31:0] decs, input logic [1:0] best);
      logic [1:0] cur;
      logic [7:0] d;
      logic [7:0] r;
      cur = best;
      r   = 8'h00;
      for (int t = FS - 1; t >= 0; t--) begin
         r[2*t +: 2] = cur;
         d   = decs[8*t +: 8];
         cur = d[2*cur +: 2];
      end
      return r;
   endfunction

   task automatic write_frame(input logic [31:0] decs, input logic [1:0] best, input bit rnd);
      for (int t = 0; t < FS; t++) begin
         if (rnd) begin
            int g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               i_en_t = ($urandom_range(0, 1) == 1);
               @(posedge clk); #1;
            end
         end
         i_en_td      = 1'b1;
         i_dec        = decs[8*t +: 8];
         i_best_state = (t == FS - 1) ? best : 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         i_en_td = 1'b0;
      end
      last_wr_n = ncyc;
      i_en_t    = 1'b1;
   endtask

   task automatic get_out(output out_t o);
      int n = 0;
      while (out_q.size() <= rd_idx && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (out_q.size() > rd_idx) begin
         o = out_q[rd_idx];
         rd_idx++;
      end else begin
         checks++;
         failures++;
         $display("FAIL get_out: no o_valid within 100 cycles");
         o = '{2'b00, 1'b0, -1};
      end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] exp, input bit timing);
      out_t o;
      for (int t = 0; t < FS; t++) begin
         get_out(o);
         check($sformatf("%s_bits%0d", tag, t), 32'(o.bits), 32'(exp[2*t +: 2]));
         check($sformatf("%s_done%0d", tag, t), 32'(o.done), 32'(t == FS - 1));
         if (timing) check($sformatf("%s_lat%0d", tag, t), 32'(o.cyc - last_wr_n), 32'(FS + 1 + t));
      end
   endtask

   task automatic wait_frame_done(input string tag);
      int n = 0;
      while (!o_frame_done && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, 32'(o_frame_done), 32'd1);
   endtask

   initial begin
      logic [12:0] pat;
      int          stall_off [4];
      int          ovr_base;
      out_t        o;

      // {decision vectors step3..step0, best state, expected pairs step3..step0}
      vecs[0] = '{32'h100C_0000, 2'b10, 8'h9C};
      vecs[1] = '{32'h0000_0000, 2'b11, 8'hC0};
      vecs[2] = '{32'hFFFF_FFFF, 2'b01, 8'h7F};
      vecs[3] = '{32'hE4E4_E4E4, 2'b10, 8'hAA};
      vecs[4] = '{32'h1B1B_1B1B, 2'b00, 8'h33};
      vecs[5] = '{32'h100C_00FF, 2'b10, 8'h9C};

      rst          = 1'b1;
      i_en_td      = 1'b0;
      i_en_t       = 1'b1;
      i_dec        = 8'h00;
      i_best_state = 2'b00;
      #2;
      check("reset_outputs", {27'd0, o_bits, o_valid, o_frame_done, o_busy, o_overrun}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_reset_outputs", {27'd0, o_bits, o_valid, o_frame_done, o_busy, o_overrun}, 32'd0);

      // Table-driven frames with i_en_t held high
      for (int v = 0; v < 6; v++) begin
         write_frame(vecs[v].decs, vecs[v].best, 1'b0);
         check($sformatf("vec%0d_busy_rise", v), 32'(o_busy), 32'd1);
         check_frame($sformatf("vec%0d", v), vecs[v].exp, 1'b1);
         @(posedge clk); #1;
         check($sformatf("vec%0d_busy_fall", v), 32'(o_busy), 32'd0);
      end

      // Stalls: 3 cycles mid-TRACE, 2 cycles mid-OUTPUT
      pat          = 13'b1110011110001;
      stall_off[0] = 8;
      stall_off[1] = 11;
      stall_off[2] = 12;
      stall_off[3] = 13;
      write_frame(vecs[0].decs, vecs[0].best, 1'b0);
      for (int j = 0; j < 13; j++) begin
         check($sformatf("stall_busy%0d", j), 32'(o_busy), 32'd1);
         i_en_t = pat[j];
         @(posedge clk); #1;
      end
      i_en_t = 1'b1;
      check("stall_busy_end", 32'(o_busy), 32'd0);
      check("stall_done_end", 32'(o_frame_done), 32'd1);
      for (int t = 0; t < FS; t++) begin
         get_out(o);
         check($sformatf("stall_bits%0d", t), 32'(o.bits), 32'(vecs[0].exp[2*t +: 2]));
         check($sformatf("stall_cyc%0d", t), 32'(o.cyc - last_wr_n), 32'(stall_off[t]));
      end

      // Overrun: two write strobes during TRACE
      @(posedge clk); #1;
      ovr_base = ovr_cnt;
      write_frame(vecs[0].decs, vecs[0].best, 1'b0);
      i_en_td = 1'b1; i_dec = 8'hFF;
      @(posedge clk); #1;
      i_en_td = 1'b0;
      @(posedge clk); #1;
      i_en_td = 1'b1; i_dec = 8'hAA;
      @(posedge clk); #1;
      i_en_td = 1'b0;
      check_frame("ovr", vecs[0].exp, 1'b1);
      check("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'd2);
      @(posedge clk); #1;
      write_frame(vecs[4].decs, vecs[4].best, 1'b0);
      check_frame("ovr_next", vecs[4].exp, 1'b1);

      // Back-to-back frames: second starts right after o_frame_done
      @(posedge clk); #1;
      ovr_base = ovr_cnt;
      write_frame(vecs[2].decs, vecs[2].best, 1'b0);
      wait_frame_done("b2b_a");
      write_frame(vecs[3].decs, vecs[3].best, 1'b0);
      check_frame("b2b_a", vecs[2].exp, 1'b0);
      check_frame("b2b_b", vecs[3].exp, 1'b1);
      check("b2b_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

      // Asynchronous reset after two outputs
      @(posedge clk); #1;
      write_frame(vecs[0].decs, vecs[0].best, 1'b0);
      begin
         int n = 0;
         while (out_q.size() < rd_idx + 2 && n < 40) begin
            @(negedge clk); #1;
            n++;
         end
      end
      check("rst_pre_valid", 32'(o_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_async_outputs", {27'd0, o_bits, o_valid, o_frame_done, o_busy, o_overrun}, 32'd0);
      rd_idx = out_q.size();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      write_frame(vecs[4].decs, vecs[4].best, 1'b0);
      check_frame("post_rst", vecs[4].exp, 1'b1);

      // Random frames with random write gaps and trace/output stalls
      for (int f = 0; f < 200; f++) begin
         logic [31:0] decs;
         logic [1:0]  best;
         int          n;
         decs = $urandom;
         best = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         write_frame(decs, best, 1'b1);
         n = 0;
         while (!o_frame_done && n < 200) begin
            i_en_t = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
         end
         i_en_t = 1'b1;
         check_frame($sformatf("rnd%0d", f), model(decs, best), 1'b0);
      end

      check("stray_frame_done", 32'(stray_done), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
